// File: rtl/gpio_bus_master_if.sv
// Bundle between the word-request side and the byte-wide cs/rd/wr/ready peripheral bus.
// The master modport is the bus initiator; the slave modport is the CPU plus peripheral side.
interface gpio_bus_master_if;
    // Request handshake: a request transfers on a clk edge where req_valid & req_ready are both 1.
    // req_we/req_addr/req_be/req_wdata must be stable while req_valid is high. rsp_valid is a
    // one-cycle pulse with no back-pressure; rsp_rdata/rsp_err are meaningful only with it.
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [31:0] req_addr;
    logic [3:0]  req_be;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        cs;
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [7:0]  data_o;
    logic [7:0]  data_i;
    logic        ready;
    logic        irq;
    logic        irq_evt;

    modport master (
        input  req_valid, req_we, req_addr, req_be, req_wdata, data_i, ready, irq,
        output req_ready, rsp_valid, rsp_rdata, rsp_err, cs, rd, wr, addr, data_o, irq_evt
    );

    modport slave (
        output req_valid, req_we, req_addr, req_be, req_wdata, data_i, ready, irq,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err, cs, rd, wr, addr, data_o, irq_evt
    );
endinterface

// File: rtl/gpio_bus_master.sv
// Word-to-byte initiator: splits a 32-bit request into up to four four-phase byte cycles.
// Optional STROBE timeout is compiled in with the macro GPIO_BUSM_TIMEOUT_EN.
module gpio_bus_master #(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic               clk,
    input  logic               rst,
    gpio_bus_master_if.master  bus,
    output logic [2:0]         dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_SETUP   = 3'd1,
        S_STROBE  = 3'd2,
        S_RELEASE = 3'd3,
        S_NEXT    = 3'd4,
        S_RESP    = 3'd5
    } state_t;

    state_t      state;
    logic        ready_m, ready_s;
    logic        irq_m, irq_s, irq_s_d;
    logic        irq_evt_r;
    logic [7:0]  cap;
    logic        we;
    logic [31:0] base;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [2:0]  idx;
    logic [31:0] acc;
    logic        req_ready_r;
    logic        rsp_valid_r;
    logic        cs_r, rd_r, wr_r;
    logic [31:0] addr_r;
    logic [7:0]  data_o_r;
    logic        err;
    logic        strobe_abort;

    // ready is sampled raw into cap so read data is held across the synchronizer delay.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ready_m   <= 1'b0;
            ready_s   <= 1'b0;
            irq_m     <= 1'b0;
            irq_s     <= 1'b0;
            irq_s_d   <= 1'b0;
            irq_evt_r <= 1'b0;
            cap       <= 8'h00;
        end else begin
            ready_m   <= bus.ready;
            ready_s   <= ready_m;
            irq_m     <= bus.irq;
            irq_s     <= irq_m;
            irq_s_d   <= irq_s;
            irq_evt_r <= irq_s & ~irq_s_d;
            if (bus.ready && state == S_STROBE) cap <= bus.data_i;
        end
    end

`ifdef GPIO_BUSM_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CW-1:0] cnt;

    // Abort on the cycle that would complete TIMEOUT_CYCLES STROBE cycles; a late ready still wins.
    assign strobe_abort = (state == S_STROBE) && !ready_s && (cnt == CW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
            err <= 1'b0;
        end else begin
            if (state == S_IDLE && bus.req_valid) err <= 1'b0;
            else if (strobe_abort)                err <= 1'b1;
            if (state == S_STROBE) cnt <= cnt + CW'(1);
            else                   cnt <= '0;
        end
    end
`else
    assign strobe_abort = 1'b0;
    assign err          = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= S_IDLE;
            req_ready_r <= 1'b1;
            rsp_valid_r <= 1'b0;
            cs_r        <= 1'b0;
            rd_r        <= 1'b0;
            wr_r        <= 1'b0;
            addr_r      <= 32'h0;
            data_o_r    <= 8'h00;
            we          <= 1'b0;
            base        <= 32'h0;
            be          <= 4'h0;
            wdata       <= 32'h0;
            idx         <= 3'd0;
            acc         <= 32'h0;
        end else begin
            rsp_valid_r <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (bus.req_valid) begin
                        we          <= bus.req_we;
                        base        <= bus.req_addr & ~32'h3;
                        be          <= bus.req_be;
                        wdata       <= bus.req_wdata;
                        idx         <= 3'd0;
                        acc         <= 32'h0;
                        req_ready_r <= 1'b0;
                        state       <= S_NEXT;
                    end
                end
                S_NEXT: begin
                    if (idx == 3'd4) begin
                        rsp_valid_r <= 1'b1;
                        state       <= S_RESP;
                    end else if (!be[idx[1:0]] || err) begin
                        idx <= idx + 3'd1;
                    end else begin
                        cs_r   <= 1'b1;
                        addr_r <= base + {30'h0, idx[1:0]};
                        if (we) data_o_r <= wdata[8*idx[1:0] +: 8];
                        state  <= S_SETUP;
                    end
                end
                S_SETUP: begin
                    rd_r  <= ~we;
                    wr_r  <= we;
                    state <= S_STROBE;
                end
                S_STROBE: begin
                    if (ready_s) begin
                        if (!we) acc[8*idx[1:0] +: 8] <= cap;
                        cs_r  <= 1'b0;
                        rd_r  <= 1'b0;
                        wr_r  <= 1'b0;
                        state <= S_RELEASE;
                    end else if (strobe_abort) begin
                        cs_r  <= 1'b0;
                        rd_r  <= 1'b0;
                        wr_r  <= 1'b0;
                        state <= S_RELEASE;
                    end
                end
                S_RELEASE: begin
                    if (!ready_s) begin
                        idx   <= idx + 3'd1;
                        state <= S_NEXT;
                    end
                end
                S_RESP: begin
                    req_ready_r <= 1'b1;
                    state       <= S_IDLE;
                end
                default: begin
                    req_ready_r <= 1'b1;
                    state       <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.req_ready = req_ready_r;
    assign bus.rsp_valid = rsp_valid_r;
    assign bus.rsp_rdata = acc;
    assign bus.rsp_err   = err;
    assign bus.cs        = cs_r;
    assign bus.rd        = rd_r;
    assign bus.wr        = wr_r;
    assign bus.addr      = addr_r;
    assign bus.data_o    = data_o_r;
    assign bus.irq_evt   = irq_evt_r;
    assign dbg_state     = state;

endmodule

// File: tb/tb_gpio_bus_master.sv
// Directed bench for gpio_bus_master against a small GPIO-like byte peripheral model.
`timescale 1ns/1ps
module tb_gpio_bus_master;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [2:0] dbg_state;
    int         vectors = 0;
    int         miscompares = 0;

    gpio_bus_master_if bus();

    gpio_bus_master #(.TIMEOUT_CYCLES(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .dbg_state (dbg_state)
    );

    always #5 clk = ~clk;

    // peripheral: 0-3 out, 4 ctr (bit0 irq enable), 8 status (write-1-to-clear), 12-15 inp
    logic [7:0] mem [16];
    int         rdly = 1;
    int         fdly = 1;
    bit         periph_en = 1'b1;
    logic [3:0] pa;

    assign bus.irq = mem[8][0] & mem[4][0];

    initial begin
        bus.ready  = 1'b0;
        bus.data_i = 8'h00;
        forever begin
            @(negedge clk);
            if (periph_en && bus.cs && (bus.rd || bus.wr) && !bus.ready) begin
                repeat (rdly) @(negedge clk);
                if (bus.cs) begin
                    pa = bus.addr[3:0];
                    if (bus.wr) begin
                        if (pa == 4'd8) mem[8] = mem[8] & ~bus.data_o;
                        else            mem[pa] = bus.data_o;
                    end else begin
                        bus.data_i = mem[pa];
                    end
                    bus.ready = 1'b1;
                    while (bus.cs) @(negedge clk);
                    repeat (fdly) @(negedge clk);
                    bus.ready = 1'b0;
                end
            end
        end
    end

    // monitor: one entry per strobe start {wr, addr[7:0], write byte or 0}
    logic [16:0] obs_q[$];
    logic [16:0] exp_q[$];
    int   rsp_cnt = 0, irq_cnt = 0, cs_rise_cnt = 0;
    int   gap = 100, min_gap = 100;
    logic strobe_d = 1'b0, cs_d = 1'b0;

    always @(negedge clk) begin
        if ((bus.rd || bus.wr) && !strobe_d)
            obs_q.push_back({bus.wr, bus.addr[7:0], bus.wr ? bus.data_o : 8'h00});
        strobe_d = bus.rd || bus.wr;
        if (bus.cs && !cs_d) begin
            cs_rise_cnt++;
            if (gap < min_gap) min_gap = gap;
        end
        gap  = bus.cs ? 0 : gap + 1;
        cs_d = bus.cs;
        if (bus.rsp_valid) rsp_cnt++;
        if (bus.irq_evt)   irq_cnt++;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic do_req(input logic we, input logic [31:0] a, input logic [3:0] be,
                          input logic [31:0] wd, output logic [31:0] rdata,
                          output logic err, output int lat);
        int  n;
        bit  got;
        n = 0;
        while (!bus.req_ready && n < 200) begin @(negedge clk); n++; end
        bus.req_valid = 1'b1; bus.req_we = we; bus.req_addr = a; bus.req_be = be; bus.req_wdata = wd;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        lat = 0; rdata = 'x; err = 1'bx; got = 0;
        for (int i = 0; i < 2000 && !got; i++) begin
            @(negedge clk);
            lat++;
            if (lat == 1) begin
                vectors++;
                if (bus.req_ready !== 1'b0) begin miscompares++; $display("FAIL req_ready_busy: got %0b expected 0", bus.req_ready); end
            end
            if (bus.rsp_valid) begin rdata = bus.rsp_rdata; err = bus.rsp_err; got = 1; end
        end
        vectors++;
        if (!got) begin miscompares++; $display("FAIL rsp_arrival: got no rsp_valid expected one within 2000 cycles"); end
        @(negedge clk);
        vectors++;
        if ({bus.req_ready, bus.rsp_valid} !== 2'b10) begin
            miscompares++; $display("FAIL req_ready_after_rsp: got ready=%0b valid=%0b expected ready=1 valid=0", bus.req_ready, bus.rsp_valid);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        vectors++; if (bus.req_ready !== 1'b1) begin miscompares++; $display("FAIL reset_req_ready: got %0b expected 1", bus.req_ready); end
        vectors++; if (bus.rsp_valid !== 1'b0) begin miscompares++; $display("FAIL reset_rsp_valid: got %0b expected 0", bus.rsp_valid); end
        vectors++; if (bus.rsp_rdata !== 32'h0) begin miscompares++; $display("FAIL reset_rsp_rdata: got %h expected 0", bus.rsp_rdata); end
        vectors++; if (bus.rsp_err !== 1'b0) begin miscompares++; $display("FAIL reset_rsp_err: got %0b expected 0", bus.rsp_err); end
        vectors++; if ({bus.cs, bus.rd, bus.wr} !== 3'b000) begin miscompares++; $display("FAIL reset_strobes: got %b expected 000", {bus.cs, bus.rd, bus.wr}); end
        vectors++; if (bus.addr !== 32'h0) begin miscompares++; $display("FAIL reset_addr: got %h expected 0", bus.addr); end
        vectors++; if (bus.data_o !== 8'h0) begin miscompares++; $display("FAIL reset_data_o: got %h expected 0", bus.data_o); end
        vectors++; if (bus.irq_evt !== 1'b0) begin miscompares++; $display("FAIL reset_irq_evt: got %0b expected 0", bus.irq_evt); end
        rst = 1'b0;
        @(negedge clk);
        vectors++; if (dbg_state !== 3'd0) begin miscompares++; $display("FAIL reset_state_idle: got %0d expected 0", dbg_state); end
        vectors++; if (bus.req_ready !== 1'b1) begin miscompares++; $display("FAIL reset_release_ready: got %0b expected 1", bus.req_ready); end
    endtask

    task automatic test_full_write();
        logic [31:0] rd_v; logic er; int lat; int rc;
        rdly = 1; fdly = 1;
        obs_q.delete(); exp_q.delete();
        exp_q.push_back({1'b1, 8'h00, 8'h01}); exp_q.push_back({1'b1, 8'h01, 8'h0F});
        exp_q.push_back({1'b1, 8'h02, 8'hC3}); exp_q.push_back({1'b1, 8'h03, 8'hA5});
        rc = rsp_cnt;
        do_req(1'b1, 32'h0, 4'hF, 32'hA5C3_0F01, rd_v, er, lat);
        #1;
        vectors++; if (obs_q.size() != exp_q.size()) begin miscompares++; $display("FAIL wr_cycle_count: got %0d expected %0d", obs_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            vectors++; if (obs_q[i] !== exp_q[i]) begin miscompares++; $display("FAIL wr_cycle_%0d: got %h expected %h", i, obs_q[i], exp_q[i]); end
        end
        vectors++; if ({mem[3], mem[2], mem[1], mem[0]} !== 32'hA5C3_0F01) begin miscompares++; $display("FAIL wr_gpio_out: got %h expected a5c30f01", {mem[3], mem[2], mem[1], mem[0]}); end
        vectors++; if (rsp_cnt - rc != 1) begin miscompares++; $display("FAIL wr_rsp_pulses: got %0d expected 1", rsp_cnt - rc); end
        vectors++; if (er !== 1'b0) begin miscompares++; $display("FAIL wr_rsp_err: got %0b expected 0", er); end
    endtask

    task automatic test_full_read();
        logic [31:0] rd_v; logic er; int lat;
        rdly = 0; fdly = 2;
        {mem[15], mem[14], mem[13], mem[12]} = 32'h1234_5678;
        obs_q.delete(); exp_q.delete();
        for (int i = 0; i < 4; i++) exp_q.push_back({1'b0, 8'(12 + i), 8'h00});
        gap = 100; min_gap = 100;
        do_req(1'b0, 32'hC, 4'hF, 32'h0, rd_v, er, lat);
        #1;
        vectors++; if (rd_v !== 32'h1234_5678) begin miscompares++; $display("FAIL rd_rdata: got %h expected 12345678", rd_v); end
        vectors++; if (obs_q.size() != exp_q.size()) begin miscompares++; $display("FAIL rd_cycle_count: got %0d expected %0d", obs_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            vectors++; if (obs_q[i] !== exp_q[i]) begin miscompares++; $display("FAIL rd_cycle_%0d: got %h expected %h", i, obs_q[i], exp_q[i]); end
        end
        vectors++; if (min_gap < 1 || min_gap >= 100) begin miscompares++; $display("FAIL rd_cs_gap: got %0d expected 1..99", min_gap); end
        vectors++; if (er !== 1'b0) begin miscompares++; $display("FAIL rd_rsp_err: got %0b expected 0", er); end
    endtask

    task automatic test_partial();
        logic [31:0] rd_v; logic er; int lat; int cr;
        rdly = 2; fdly = 0;
        mem[4] = 8'hFF; mem[5] = 8'hFF; mem[6] = 8'hFF; mem[7] = 8'hFF;
        obs_q.delete();
        do_req(1'b1, 32'h4, 4'h1, 32'h0, rd_v, er, lat);
        #1;
        vectors++; if (obs_q.size() != 1) begin miscompares++; $display("FAIL pw_cycle_count: got %0d expected 1", obs_q.size()); end
        else begin vectors++; if (obs_q[0] !== {1'b1, 8'h04, 8'h00}) begin miscompares++; $display("FAIL pw_cycle: got %h expected 10400", obs_q[0]); end end
        vectors++; if ({mem[7], mem[6], mem[5], mem[4]} !== 32'hFFFF_FF00) begin miscompares++; $display("FAIL pw_ctr: got %h expected ffffff00", {mem[7], mem[6], mem[5], mem[4]}); end
        // low address bits are ignored: 0x3 with be=8 targets byte address 3
        obs_q.delete();
        do_req(1'b1, 32'h3, 4'h8, 32'h7700_0000, rd_v, er, lat);
        #1;
        vectors++; if (obs_q.size() != 1) begin miscompares++; $display("FAIL pw_hi_count: got %0d expected 1", obs_q.size()); end
        else begin vectors++; if (obs_q[0] !== {1'b1, 8'h03, 8'h77}) begin miscompares++; $display("FAIL pw_hi_cycle: got %h expected 10377", obs_q[0]); end end
        obs_q.delete(); cr = cs_rise_cnt;
        do_req(1'b0, 32'hC, 4'h0, 32'h0, rd_v, er, lat);
        #1;
        vectors++; if (cs_rise_cnt != cr) begin miscompares++; $display("FAIL be0_cs: got %0d cs cycles expected 0", cs_rise_cnt - cr); end
        vectors++; if (lat != 6) begin miscompares++; $display("FAIL be0_latency: got %0d expected 6", lat); end
        vectors++; if (rd_v !== 32'h0) begin miscompares++; $display("FAIL be0_rdata: got %h expected 0", rd_v); end
        do_req(1'b0, 32'hC, 4'h5, 32'h0, rd_v, er, lat);
        vectors++; if (rd_v !== 32'h0034_0078) begin miscompares++; $display("FAIL be5_rdata: got %h expected 00340078", rd_v); end
    endtask

    task automatic toggle_inp(input logic [31:0] v);
        {mem[15], mem[14], mem[13], mem[12]} = v;
        if (mem[4][0]) mem[8][0] = 1'b1;
    endtask

    task automatic test_irq();
        logic [31:0] rd_v, rd2; logic er, er2; int lat, lat2; int base; int k;
        rdly = 1; fdly = 1;
        do_req(1'b1, 32'h4, 4'h1, 32'h1, rd_v, er, lat);
        #1 base = irq_cnt;
        toggle_inp(32'h0000_00FF);
        for (k = 1; k <= 20; k++) begin @(negedge clk); if (bus.irq_evt) break; end
        vectors++; if (k < 3 || k > 4) begin miscompares++; $display("FAIL irq_latency: got %0d cycles expected 3..4", k); end
        repeat (10) @(negedge clk);
        #1;
        vectors++; if (irq_cnt - base != 1) begin miscompares++; $display("FAIL irq_pulses: got %0d expected 1", irq_cnt - base); end
        do_req(1'b0, 32'h8, 4'h1, 32'h0, rd_v, er, lat);
        vectors++; if (rd_v !== 32'h0000_0001) begin miscompares++; $display("FAIL irq_status: got %h expected 00000001", rd_v); end
        do_req(1'b1, 32'h8, 4'h1, 32'h1, rd_v, er, lat);
        repeat (6) @(negedge clk);
        #1 base = irq_cnt;
        rdly = 2;
        fork
            do_req(1'b0, 32'hC, 4'hF, 32'h0, rd2, er2, lat2);
            begin repeat (8) @(negedge clk); toggle_inp(32'h0000_00AA); end
        join
        repeat (10) @(negedge clk);
        #1;
        vectors++; if (irq_cnt - base != 1) begin miscompares++; $display("FAIL irq_during_read: got %0d pulses expected 1", irq_cnt - base); end
    endtask

`ifdef GPIO_BUSM_TIMEOUT_EN
    task automatic test_timeout();
        logic [31:0] rd_v; logic er; int lat;
        periph_en = 1'b0;
        obs_q.delete();
        do_req(1'b0, 32'hC, 4'hF, 32'h0, rd_v, er, lat);
        #1;
        vectors++; if (er !== 1'b1) begin miscompares++; $display("FAIL to_err: got %0b expected 1", er); end
        vectors++; if (rd_v !== 32'h0) begin miscompares++; $display("FAIL to_rdata: got %h expected 0", rd_v); end
        vectors++; if (obs_q.size() != 1) begin miscompares++; $display("FAIL to_cycles: got %0d expected 1", obs_q.size()); end
        periph_en = 1'b1;
        do_req(1'b0, 32'hC, 4'h1, 32'h0, rd_v, er, lat);
        vectors++; if (er !== 1'b0) begin miscompares++; $display("FAIL to_err_cleared: got %0b expected 0", er); end
    endtask
`endif

    task automatic test_reset_mid();
        logic [31:0] rd_v; logic er; int lat; int rc; bit found;
        rdly = 10; fdly = 1;
        bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_addr = 32'h0; bus.req_be = 4'hF; bus.req_wdata = 32'h1122_3344;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        found = 0;
        for (int n = 0; n < 500 && !found; n++) begin @(negedge clk); if (bus.wr && bus.addr == 32'h2) found = 1; end
        vectors++; if (!found) begin miscompares++; $display("FAIL rstmid_reach: got no strobe at addr 2 expected one"); end
        rc = rsp_cnt;
        rst = 1'b1;
        #1;
        vectors++; if ({bus.cs, bus.wr, bus.rsp_valid} !== 3'b000) begin miscompares++; $display("FAIL rstmid_drop: got cs/wr/rsp=%b expected 000", {bus.cs, bus.wr, bus.rsp_valid}); end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        vectors++; if (bus.req_ready !== 1'b1) begin miscompares++; $display("FAIL rstmid_ready: got %0b expected 1", bus.req_ready); end
        repeat (15) @(negedge clk);
        #1;
        vectors++; if (rsp_cnt != rc) begin miscompares++; $display("FAIL rstmid_no_rsp: got %0d responses expected 0", rsp_cnt - rc); end
        vectors++; if (mem[2] !== 8'hC3) begin miscompares++; $display("FAIL rstmid_byte2: got %h expected c3", mem[2]); end
        rdly = 1;
        obs_q.delete();
        @(negedge clk);
        do_req(1'b1, 32'h0, 4'hF, 32'hCAFE_BABE, rd_v, er, lat);
        #1;
        vectors++; if ({mem[3], mem[2], mem[1], mem[0]} !== 32'hCAFE_BABE) begin miscompares++; $display("FAIL rstmid_next_out: got %h expected cafebabe", {mem[3], mem[2], mem[1], mem[0]}); end
        vectors++; if (obs_q.size() != 4) begin miscompares++; $display("FAIL rstmid_next_cycles: got %0d expected 4", obs_q.size()); end
        vectors++; if (er !== 1'b0) begin miscompares++; $display("FAIL rstmid_next_err: got %0b expected 0", er); end
    endtask

    initial begin
        for (int i = 0; i < 16; i++) mem[i] = 8'h00;
        bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_addr = 32'h0; bus.req_be = 4'h0; bus.req_wdata = 32'h0;
        test_reset();
        test_full_write();
        test_full_read();
        test_partial();
        test_irq();
`ifdef GPIO_BUSM_TIMEOUT_EN
        test_timeout();
`endif
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
